// File: rtl/snake_control.sv
// snake_control: snake body store, movement FSM, target handshake, score and pixel lookup.
// Optional feature macro SNAKE_WRAP_EN: head wraps at the borders instead of dying on walls.
module snake_control #(
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 4,
   parameter int TICK_DIV = 5_000_000,
   parameter int H_MAX    = 160,
   parameter int V_MAX    = 120
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTN_U,
   input  logic       BTN_D,
   input  logic       BTN_L,
   input  logic       BTN_R,
   input  logic [7:0] TARGET_ADDRH,
   input  logic [6:0] TARGET_ADDRV,
   output logic       TARGET_REACHED,
   input  logic [7:0] PIX_X,
   input  logic [6:0] PIX_Y,
   output logic       SNAKE_PIXEL,
   output logic       HEAD_PIXEL,
   output logic [7:0] SCORE,
   output logic       GAME_OVER
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;
   // Reverse directions differ only in bit 0.
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   state_t                  state_q, state_d;
   dir_t                    dir_q, dir_d, pend_q, pend_d;
   logic [TW-1:0]           tick_q, tick_d;
   logic [LW-1:0]           len_q, len_d;
   logic [7:0]              score_q, score_d;
   logic                    tr_q, tr_d;
   logic [MAX_LEN-1:0][7:0] segx_q, segx_d;
   logic [MAX_LEN-1:0][6:0] segy_q, segy_d;
   logic                    snake_pix_q, head_pix_q;

   logic       btn_any, btn_ok, step, wall, self_hit, pix_hit;
   dir_t       btn_dir;
   logic [8:0] nx;
   logic [7:0] ny;
   logic [7:0] hx;
   logic [6:0] hy;

   always_comb begin
      btn_any = BTN_U | BTN_D | BTN_L | BTN_R;
      btn_dir = D_RIGHT;
      if (BTN_U)      btn_dir = D_UP;
      else if (BTN_D) btn_dir = D_DOWN;
      else if (BTN_L) btn_dir = D_LEFT;
      btn_ok = btn_any && (btn_dir != dir_t'(dir_q ^ 2'b01));
   end

   assign step = (tick_q == TW'(TICK_DIV - 1));

   // Candidate head in one extra bit so that -1 and H_MAX/V_MAX are visible.
   always_comb begin
      nx = {1'b0, segx_q[0]};
      ny = {1'b0, segy_q[0]};
      case (pend_q)
         D_UP:    ny = ny - 8'd1;
         D_DOWN:  ny = ny + 8'd1;
         D_LEFT:  nx = nx - 9'd1;
         default: nx = nx + 9'd1;
      endcase
`ifdef SNAKE_WRAP_EN
      wall = 1'b0;
      hx = (nx == 9'h1FF) ? 8'(H_MAX - 1) : (nx == 9'(H_MAX)) ? 8'd0 : nx[7:0];
      hy = (ny == 8'hFF)  ? 7'(V_MAX - 1) : (ny == 8'(V_MAX)) ? 7'd0 : ny[6:0];
`else
      wall = (nx >= 9'(H_MAX)) || (ny >= 8'(V_MAX));
      hx = nx[7:0];
      hy = ny[6:0];
`endif
   end

   // The tail is excluded: it moves away on the same step.
   always_comb begin
      self_hit = 1'b0;
      pix_hit  = 1'b0;
      for (int j = 0; j < MAX_LEN; j++) begin
         if ((LW'(j) + LW'(1) < len_q) && segx_q[j] == hx && segy_q[j] == hy) self_hit = 1'b1;
         if ((LW'(j) < len_q) && segx_q[j] == PIX_X && segy_q[j] == PIX_Y) pix_hit = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pend_d  = pend_q;
      tick_d  = tick_q;
      len_d   = len_q;
      score_d = score_q;
      tr_d    = 1'b0;
      segx_d  = segx_q;
      segy_d  = segy_q;
      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (btn_ok) begin
               pend_d  = btn_dir;
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (btn_ok) pend_d = btn_dir;
            tick_d = step ? '0 : tick_q + 1'b1;
            if (step) begin
               dir_d = pend_q;
               if (wall || self_hit) begin
                  state_d = DEAD;
               end else begin
                  segx_d = {segx_q[MAX_LEN-2:0], hx};
                  segy_d = {segy_q[MAX_LEN-2:0], hy};
                  if (hx == TARGET_ADDRH && hy == TARGET_ADDRV) begin
                     tr_d = 1'b1;
                     if (len_q != LW'(MAX_LEN)) len_d = len_q + 1'b1;
                     if (score_q != 8'hFF)      score_d = score_q + 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         dir_q       <= D_RIGHT;
         pend_q      <= D_RIGHT;
         tick_q      <= '0;
         len_q       <= LW'(INIT_LEN);
         score_q     <= 8'd0;
         tr_q        <= 1'b0;
         snake_pix_q <= 1'b0;
         head_pix_q  <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            segx_q[i] <= 8'(20 - i);
            segy_q[i] <= 7'd60;
         end
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         pend_q      <= pend_d;
         tick_q      <= tick_d;
         len_q       <= len_d;
         score_q     <= score_d;
         tr_q        <= tr_d;
         segx_q      <= segx_d;
         segy_q      <= segy_d;
         snake_pix_q <= pix_hit;
         head_pix_q  <= (segx_q[0] == PIX_X) && (segy_q[0] == PIX_Y);
      end
   end

   assign TARGET_REACHED = tr_q;
   assign SNAKE_PIXEL    = snake_pix_q;
   assign HEAD_PIXEL     = head_pix_q;
   assign SCORE          = score_q;
   assign GAME_OVER      = (state_q == DEAD);
endmodule
